// File: rtl/conv_ctrl_pkg.sv
// Shared types and elaboration helpers for the convolution window sequencer.
// CONV_SEQ_ZERO_PAD_EN selects "same" padding (output map matches input map).
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    WAIT_OUT = 2'd2,
    DONE     = 2'd3
  } state_t;

`ifdef CONV_SEQ_ZERO_PAD_EN
  localparam bit ZERO_PAD = 1'b1;
`else
  localparam bit ZERO_PAD = 1'b0;
`endif

  function automatic int pad_of(int k);
    return ZERO_PAD ? (k - 1) / 2 : 0;
  endfunction

  // Padding of (k-1)/2 on each side restores the full input dimension.
  function automatic int out_dim(int img, int k);
    return img - k + 1 + 2 * pad_of(k);
  endfunction

  function automatic int tap_count(int k);
    return k * k;
  endfunction

  function automatic int idx_width(int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/tap_counter.sv
// Nested kernel-row/kernel-column tap counter with clear/enable and last-tap flag.
// Exposes next-state values so the parent can register its outputs from them.
module tap_counter #(
  parameter int K  = 3,
  parameter int KW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [KW-1:0] kr_d,
  output logic [KW-1:0] kc_d,
  output logic          last
);

  localparam logic [KW-1:0] KMAX = KW'(K - 1);

  logic [KW-1:0] kr_q, kc_q;

  assign last = (kr_q == KMAX) && (kc_q == KMAX);

  always_comb begin
    kr_d = kr_q;
    kc_d = kc_q;
    if (clr) begin
      kr_d = '0;
      kc_d = '0;
    end else if (en) begin
      if (kc_q == KMAX) begin
        kc_d = '0;
        kr_d = (kr_q == KMAX) ? '0 : kr_q + 1'b1;
      end else begin
        kc_d = kc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kr_q <= '0;
      kc_q <= '0;
    end else begin
      kr_q <= kr_d;
      kc_q <= kc_d;
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// Walks kernel taps per output pixel and hands each pixel off with valid/ready.
// CONV_SEQ_ZERO_PAD_EN enables "same" padding with out-of-map taps flagged as pad.
//   state    | meaning
//   IDLE     | waiting for start
//   FETCH    | one tap read per cycle
//   WAIT_OUT | result presented, waiting for out_ready
//   DONE     | one-cycle done pulse
module conv_window_sequencer
  import conv_ctrl_pkg::*;
#(
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28,
  parameter int KERNAL_SIZE = 3,
  parameter int ADDR_WIDTH  = 10,
  parameter int COORD_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     layer_active,
  output logic                     rd_en,
  output logic [ADDR_WIDTH-1:0]    rd_addr,
  output logic [2*KERNAL_SIZE-1:0] tap_idx,
  output logic                     tap_first,
  output logic                     tap_last,
  output logic                     pad_tap,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COORD_WIDTH-1:0]   out_row,
  output logic [COORD_WIDTH-1:0]   out_col,
  output logic                     done
);

  localparam int OUT_W = out_dim(IMG_WIDTH, KERNAL_SIZE);
  localparam int OUT_H = out_dim(IMG_HEIGHT, KERNAL_SIZE);
  localparam int PAD   = pad_of(KERNAL_SIZE);
  localparam int TAPS  = tap_count(KERNAL_SIZE);
  localparam int KW    = idx_width(KERNAL_SIZE);
  localparam int TW    = 2 * KERNAL_SIZE;
  localparam int TRW   = ((COORD_WIDTH > KW) ? COORD_WIDTH : KW) + 1;

  state_t                 state_q, state_d;
  logic [COORD_WIDTH-1:0] row_q, row_d, col_q, col_d;
  logic                   tap_clr, tap_en, tap_wrap;
  logic [KW-1:0]          kr_nxt, kc_nxt;

  tap_counter #(.K(KERNAL_SIZE), .KW(KW)) u_tap_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (tap_clr),
    .en    (tap_en),
    .kr_d  (kr_nxt),
    .kc_d  (kc_nxt),
    .last  (tap_wrap)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    tap_clr = 1'b0;
    tap_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          row_d   = '0;
          col_d   = '0;
          tap_clr = 1'b1;
        end
      end
      FETCH: begin
        tap_en = 1'b1;
        if (tap_wrap) state_d = WAIT_OUT;
      end
      WAIT_OUT: begin
        if (out_ready) begin
          tap_clr = 1'b1;
          if (row_q == COORD_WIDTH'(OUT_H - 1) && col_q == COORD_WIDTH'(OUT_W - 1)) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
            if (col_q == COORD_WIDTH'(OUT_W - 1)) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic                     fetch_d, oob;
  logic [TRW-1:0]           tr, tc, ar, ac;
  logic [TW-1:0]            idx;
  logic                     layer_active_d, rd_en_d, tap_first_d, tap_last_d, pad_tap_d;
  logic                     out_valid_d, done_d;
  logic [ADDR_WIDTH-1:0]    rd_addr_d;
  logic [TW-1:0]            tap_idx_d;
  logic [COORD_WIDTH-1:0]   out_row_d, out_col_d;

  // Outputs are computed from next-state values so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    fetch_d = (state_d == FETCH);
    tr      = TRW'(row_d) + TRW'(kr_nxt);
    tc      = TRW'(col_d) + TRW'(kc_nxt);
`ifdef CONV_SEQ_ZERO_PAD_EN
    oob = (tr < TRW'(PAD)) || (tr >= TRW'(IMG_HEIGHT + PAD)) ||
          (tc < TRW'(PAD)) || (tc >= TRW'(IMG_WIDTH + PAD));
`else
    oob = 1'b0;
`endif
    ar  = tr - TRW'(PAD);
    ac  = tc - TRW'(PAD);
    idx = TW'(kr_nxt) * TW'(KERNAL_SIZE) + TW'(kc_nxt);

    layer_active_d = (state_d != IDLE);
    rd_en_d        = fetch_d && !oob;
    rd_addr_d      = rd_en_d ? ADDR_WIDTH'(ar) * ADDR_WIDTH'(IMG_WIDTH) + ADDR_WIDTH'(ac) : '0;
    tap_idx_d      = fetch_d ? idx : '0;
    tap_first_d    = fetch_d && (idx == '0);
    tap_last_d     = fetch_d && (idx == TW'(TAPS - 1));
    pad_tap_d      = fetch_d && oob;
    out_valid_d    = (state_d == WAIT_OUT);
    done_d         = (state_d == DONE);
    out_row_d      = row_d;
    out_col_d      = col_d;
  end

  logic                   layer_active_q, rd_en_q, tap_first_q, tap_last_q, pad_tap_q;
  logic                   out_valid_q, done_q;
  logic [ADDR_WIDTH-1:0]  rd_addr_q;
  logic [TW-1:0]          tap_idx_q;
  logic [COORD_WIDTH-1:0] out_row_q, out_col_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      row_q          <= '0;
      col_q          <= '0;
      layer_active_q <= 1'b0;
      rd_en_q        <= 1'b0;
      rd_addr_q      <= '0;
      tap_idx_q      <= '0;
      tap_first_q    <= 1'b0;
      tap_last_q     <= 1'b0;
      pad_tap_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      out_row_q      <= '0;
      out_col_q      <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      col_q          <= col_d;
      layer_active_q <= layer_active_d;
      rd_en_q        <= rd_en_d;
      rd_addr_q      <= rd_addr_d;
      tap_idx_q      <= tap_idx_d;
      tap_first_q    <= tap_first_d;
      tap_last_q     <= tap_last_d;
      pad_tap_q      <= pad_tap_d;
      out_valid_q    <= out_valid_d;
      out_row_q      <= out_row_d;
      out_col_q      <= out_col_d;
      done_q         <= done_d;
    end
  end

  assign layer_active = layer_active_q;
  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign tap_idx      = tap_idx_q;
  assign tap_first    = tap_first_q;
  assign tap_last     = tap_last_q;
  assign pad_tap      = pad_tap_q;
  assign out_valid    = out_valid_q;
  assign out_row      = out_row_q;
  assign out_col      = out_col_q;
  assign done         = done_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Self-checking bench: literal start-up vector table, mid-layer reset, and
// randomized full layers checked against a window/tap enumeration model.
module tb_conv_window_sequencer;

  localparam int W = 5, H = 5, K = 3, AW = 10, CW = 5;
`ifdef CONV_SEQ_ZERO_PAD_EN
  localparam int P = (K - 1) / 2, OW = W, OH = H;
`else
  localparam int P = 0, OW = W - K + 1, OH = H - K + 1;
`endif

  logic          clk, reset, start, out_ready;
  logic          layer_active, rd_en, tap_first, tap_last, pad_tap, out_valid, done;
  logic [AW-1:0] rd_addr;
  logic [2*K-1:0] tap_idx;
  logic [CW-1:0] out_row, out_col;

  conv_window_sequencer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNAL_SIZE(K), .ADDR_WIDTH(AW), .COORD_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .layer_active(layer_active),
    .rd_en(rd_en), .rd_addr(rd_addr), .tap_idx(tap_idx), .tap_first(tap_first),
    .tap_last(tap_last), .pad_tap(pad_tap), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_col(out_col), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, done_cnt = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Reference: tap t of window (r,c) reads input pixel (r+kr-P, c+kc-P).
  task automatic exp_tap(input int r, input int c, input int t,
                         output int en, output int addr, output int pad);
    int tr, tcol;
    tr   = r + t / K - P;
    tcol = c + t % K - P;
    pad  = (tr < 0 || tr >= H || tcol < 0 || tcol >= W) ? 1 : 0;
    en   = 1 - pad;
    addr = pad ? 0 : tr * W + tcol;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".act"}, layer_active, 0);
    chk({tag, ".rd_en"}, rd_en, 0);
    chk({tag, ".addr"}, rd_addr, 0);
    chk({tag, ".idx"}, tap_idx, 0);
    chk({tag, ".first"}, tap_first, 0);
    chk({tag, ".last"}, tap_last, 0);
    chk({tag, ".pad"}, pad_tap, 0);
    chk({tag, ".valid"}, out_valid, 0);
    chk({tag, ".done"}, done, 0);
  endtask

  task automatic chk_tap(input int r, input int c, input int t);
    int en, addr, pad;
    exp_tap(r, c, t, en, addr, pad);
    chk("tap.rd_en", rd_en, en);
    chk("tap.addr", rd_addr, addr);
    chk("tap.pad", pad_tap, pad);
    chk("tap.idx", tap_idx, t);
    chk("tap.first", tap_first, (t == 0) ? 1 : 0);
    chk("tap.last", tap_last, (t == K * K - 1) ? 1 : 0);
    chk("tap.valid", out_valid, 0);
    chk("tap.act", layer_active, 1);
    chk("tap.done", done, 0);
  endtask

  task automatic chk_wait(input int r, input int c);
    chk("wait.valid", out_valid, 1);
    chk("wait.row", out_row, r);
    chk("wait.col", out_col, c);
    chk("wait.rd_en", rd_en, 0);
    chk("wait.pad", pad_tap, 0);
    chk("wait.done", done, 0);
  endtask

  // Full layer: windows in raster order, K*K taps each, then a stalled handoff.
  task automatic run_layer(input int pct, input bit poke);
    int stall;
    bit acc;
    start = 1'b1; step(); start = 1'b0;
    for (int r = 0; r < OH; r++) begin
      for (int c = 0; c < OW; c++) begin
        for (int t = 0; t < K * K; t++) begin
          chk_tap(r, c, t);
          out_ready = 1'($urandom_range(1));
          start = poke && ($urandom_range(1) == 1);
          step(); start = 1'b0;
        end
        stall = 0;
        acc = 1'b0;
        while (!acc) begin
          chk_wait(r, c);
          out_ready = (int'($urandom_range(99)) < pct) || (stall >= 6);
          acc = out_ready;
          start = poke && ($urandom_range(1) == 1);
          step(); start = 1'b0;
          stall++;
        end
      end
    end
    chk("done.pulse", done, 1);
    chk("done.act", layer_active, 1);
    chk("done.valid", out_valid, 0);
    start = poke;
    out_ready = 1'($urandom_range(1));
    step(); start = 1'b0;
    chk("post_done.done", done, 0);
    chk("post_done.act", layer_active, 0);
    step();
    chk("idle_hold.act", layer_active, 0);
  endtask

  typedef struct {
    int start, ready;
    int act, rd_en, addr, idx, first, last, pad, valid, row, col, done;
  } vec_t;

  vec_t tbl[13];

`ifdef CONV_SEQ_ZERO_PAD_EN
  int en_l[9]   = '{0, 0, 0, 0, 1, 1, 0, 1, 1};
  int addr_l[9] = '{0, 0, 0, 0, 0, 1, 0, 5, 6};
  int w01_en = 0, w01_addr = 0;
`else
  int en_l[9]   = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
  int addr_l[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
  int w01_en = 1, w01_addr = 1;
`endif

  initial begin
    int wr, wc;
    tbl[0] = '{1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int t = 0; t < 9; t++)
      tbl[t + 1] = '{0, 1,  1, en_l[t], addr_l[t], t, (t == 0) ? 1 : 0, (t == 8) ? 1 : 0,
                     1 - en_l[t], 0, 0, 0, 0};
    tbl[10] = '{0, 0,  1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[11] = '{0, 1,  1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    tbl[12] = '{0, 0,  1, w01_en, w01_addr, 0, 1, 0, 1 - w01_en, 0, 0, 1, 0};

    reset = 1'b1; start = 1'b0; out_ready = 1'b0;
    step(); step();
    chk_idle("reset");
    chk("reset.row", out_row, 0);
    chk("reset.col", out_col, 0);
    reset = 1'b0;
    step();
    chk_idle("idle");

    for (int i = 0; i < 13; i++) begin
      chk($sformatf("vec%0d.act", i), layer_active, tbl[i].act);
      chk($sformatf("vec%0d.rd_en", i), rd_en, tbl[i].rd_en);
      chk($sformatf("vec%0d.addr", i), rd_addr, tbl[i].addr);
      chk($sformatf("vec%0d.idx", i), tap_idx, tbl[i].idx);
      chk($sformatf("vec%0d.first", i), tap_first, tbl[i].first);
      chk($sformatf("vec%0d.last", i), tap_last, tbl[i].last);
      chk($sformatf("vec%0d.pad", i), pad_tap, tbl[i].pad);
      chk($sformatf("vec%0d.valid", i), out_valid, tbl[i].valid);
      if (tbl[i].valid != 0) begin
        chk($sformatf("vec%0d.row", i), out_row, tbl[i].row);
        chk($sformatf("vec%0d.col", i), out_col, tbl[i].col);
      end
      chk($sformatf("vec%0d.done", i), done, tbl[i].done);
      start = 1'(tbl[i].start);
      out_ready = 1'(tbl[i].ready);
      step();
    end
    start = 1'b0;

    // Asynchronous reset in the middle of a layer.
    #2 reset = 1'b1;
    #1 chk_idle("rst_async");
    step();
    chk_idle("rst_hold");
    reset = 1'b0;
    step();
    chk_idle("rst_release");

    // Reset during FETCH of window 4, then a fresh layer from (0,0).
    out_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    repeat (40) step();
    wr = 4 / OW;
    wc = 4 % OW;
    chk_tap(wr, wc, 0);
    step();
    chk_tap(wr, wc, 1);
    step(); step();
    #2 reset = 1'b1;
    #1 chk_idle("rst_w4");
    step();
    chk_idle("rst_w4_hold");
    reset = 1'b0;
    step();
    chk_idle("rst_w4_release");
    run_layer(100, 1'b0);

    run_layer(60, 1'b1);
    run_layer(30, 1'b1);
    run_layer(90, 1'b0);

    step();
    chk("done_count", done_cnt, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
